// File: rtl/ahb_slv_pkg.sv
// ahb_slv_pkg: shared types and helpers for the AHB-Lite slave memory.
// Transfer, response, size and FSM state encodings plus lane decode.
package ahb_slv_pkg;

  typedef enum logic [1:0] {
    HT_IDLE   = 2'd0,
    HT_BUSY   = 2'd1,
    HT_NONSEQ = 2'd2,
    HT_SEQ    = 2'd3
  } htrans_e;

  typedef enum logic [1:0] {
    HR_OKAY  = 2'd0,
    HR_ERROR = 2'd1
  } hresp_e;

  typedef enum logic [2:0] {
    HS_BYTE = 3'd0,
    HS_HALF = 3'd1,
    HS_WORD = 3'd2
  } hsize_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ERR1 = 2'd2,
    S_ERR2 = 2'd3
  } slv_state_e;

  // Little-endian byte lanes touched by a beat of size sz at offset a.
  function automatic logic [3:0] byte_en(
    input logic [2:0] sz,
    input logic [1:0] a
  );
    logic [3:0] be;
    be = 4'b0000;
    case (sz)
      HS_BYTE: be = 4'b0001 << a;
      HS_HALF: be = a[1] ? 4'b1100 : 4'b0011;
      HS_WORD: be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/ahb_slv_sram.sv
// ahb_slv_sram: DEPTH x 32 word array, byte write enables.
// One write port (clocked) and one read port; contents are not reset.
module ahb_slv_sram #(
  parameter int DEPTH = 1024,
  parameter int IW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [IW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [IW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem_q [DEPTH];

  // Byte-lane write of the completing beat.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem_q[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/ahb_slv_mem.sv
// ahb_slv_mem: AHB-Lite slave SRAM with wait states and ERROR replies.
// Optional user-access guard on the top quarter: AHB_SLV_PRIV_CHK_EN.
module ahb_slv_mem
  import ahb_slv_pkg::*;
#(
  parameter int AW       = 32,
  parameter int DEPTH    = 1024,
  parameter int WAIT_MAX = 15
) (
  input  logic                          hclk,
  input  logic                          hrst,
  input  logic                          hsel,
  input  logic [AW-1:0]                 haddr,
  input  logic [1:0]                    htrans,
  input  logic                          hwrite,
  input  logic [2:0]                    hsize,
  input  logic [2:0]                    hburst,
  input  logic [3:0]                    hprot,
  input  logic [31:0]                   hwdata,
  input  logic                          hready_in,
  input  logic [$clog2(WAIT_MAX+1)-1:0] wait_cfg,
  output logic [31:0]                   hrdata,
  output logic                          hready,
  output logic [1:0]                    hresp
);

  localparam int IW = $clog2(DEPTH);
  localparam int WW = $clog2(WAIT_MAX+1);
  localparam logic [AW-1:0] DEPTH_W = AW'(DEPTH);

  slv_state_e    state_q;
  logic [WW-1:0] cnt_q;
  logic          pend_q;
  logic          wr_q;
  logic [3:0]    be_q;
  logic [IW-1:0] widx_q;
  logic          hready_q;
  hresp_e        hresp_q;
  logic [31:0]   hrdata_q;

  logic          accept;
  logic [AW-1:0] widx_full;
  logic          oor;
  logic          bad_sz;
  logic          misal;
  logic          priv_err;
  logic          err_a;
  logic [IW-1:0] raddr_a;
  logic [IW-1:0] rd_idx;
  logic          cmpl;
  logic          byp;
  logic [31:0]   sram_rdata;
  logic [31:0]   rd_d;
  logic          unused_ok;

  assign accept    = hsel & hready_in & htrans[1];
  assign widx_full = {2'b00, haddr[AW-1:2]};
  assign oor       = widx_full >= DEPTH_W;
  assign bad_sz    = hsize > 3'd2;
  assign misal     = ((hsize == HS_HALF) && haddr[0]) ||
                     ((hsize == HS_WORD) && (haddr[1:0] != 2'b00));

`ifdef AHB_SLV_PRIV_CHK_EN
  localparam logic [AW-1:0] PRIV_W = AW'(3*DEPTH/4);
  assign priv_err  = ~hprot[1] & (widx_full >= PRIV_W);
  assign unused_ok = ^{hburst, htrans[0], hprot[3:2], hprot[0]};
`else
  assign priv_err  = 1'b0;
  assign unused_ok = ^{hburst, htrans[0], hprot};
`endif

  assign err_a   = oor | bad_sz | misal | priv_err;
  assign raddr_a = haddr[IW+1:2];

  // Completion cycle of a good beat: back in IDLE with a beat pending.
  assign cmpl   = (state_q == S_IDLE) && pend_q;
  assign byp    = cmpl & wr_q & (widx_q == raddr_a);
  assign rd_idx = (state_q == S_WAIT) ? widx_q : raddr_a;

  ahb_slv_sram #(
    .DEPTH (DEPTH),
    .IW    (IW)
  ) u_sram (
    .clk   (hclk),
    .we    (cmpl & wr_q),
    .be    (be_q),
    .waddr (widx_q),
    .wdata (hwdata),
    .raddr (rd_idx),
    .rdata (sram_rdata)
  );

  // Read data with same-edge write forwarding to avoid a stale word.
  always_comb begin
    rd_d = sram_rdata;
    if (byp) begin
      for (int i = 0; i < 4; i++) begin
        if (be_q[i]) rd_d[8*i +: 8] = hwdata[8*i +: 8];
      end
    end
  end

  // Beat FSM: accept, wait countdown, two-cycle error, registered outputs.
  always_ff @(posedge hclk) begin
    if (hrst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      pend_q   <= 1'b0;
      wr_q     <= 1'b0;
      be_q     <= 4'b0000;
      widx_q   <= '0;
      hready_q <= 1'b1;
      hresp_q  <= HR_OKAY;
      hrdata_q <= '0;
    end else begin
      unique case (state_q)
        S_IDLE, S_ERR2: begin
          state_q  <= S_IDLE;
          pend_q   <= 1'b0;
          hready_q <= 1'b1;
          hresp_q  <= HR_OKAY;
          if (accept) begin
            if (err_a) begin
              state_q  <= S_ERR1;
              hready_q <= 1'b0;
              hresp_q  <= HR_ERROR;
            end else begin
              pend_q <= 1'b1;
              wr_q   <= hwrite;
              be_q   <= byte_en(hsize, haddr[1:0]);
              widx_q <= raddr_a;
              if (wait_cfg == '0) begin
                if (!hwrite) hrdata_q <= rd_d;
              end else begin
                state_q  <= S_WAIT;
                cnt_q    <= wait_cfg;
                hready_q <= 1'b0;
              end
            end
          end
        end
        S_WAIT: begin
          cnt_q <= cnt_q - WW'(1);
          if (cnt_q == WW'(1)) begin
            state_q  <= S_IDLE;
            hready_q <= 1'b1;
            if (!wr_q) hrdata_q <= rd_d;
          end
        end
        S_ERR1: begin
          state_q  <= S_ERR2;
          hready_q <= 1'b1;
          hresp_q  <= HR_ERROR;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign hready = hready_q;
  assign hresp  = hresp_q;
  assign hrdata = hrdata_q;

endmodule
